hilo_file: RTL

HI/LO register pair with an internal M/W write pipeline and read forwarding. The write side consumes the 3-bit HI/LO write flag produced alongside each ALU operation at the execute stage. The read side consumes the matching 3-bit read flag and returns forwarded HI/LO values to the execute-stage datapath. It sits beside the ALU and replaces any external HI/LO hazard stalling: all HI/LO dependencies are resolved by forwarding.

---
 rtl/hilo_file.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hilo_file.sv
// rtl/hilo_file.sv - HI/LO register pair with M/W write pipeline and read forwarding
//
// Purpose:
//   Holds the architectural HI and LO registers. Each write request from the
//   execute stage travels through an M entry and then a W entry, and commits
//   to HI/LO when it leaves W. Reads from the execute stage are resolved
//   entirely by forwarding (M over W over architectural), so HI/LO hazards
//   never need a stall.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset (overrides stall and flush)
//   stall       freeze M, W, HI and LO; no commit
//   flush_e     drop the execute-stage write request
//   flush_m     invalidate the M entry at the next edge
//   wflag_e     write flag {valid, write HI, write LO}
//   hi_wdata_e  value for HI
//   lo_wdata_e  value for LO
//   rflag_e     read flag {to GPR, depends on HI, depends on LO}
//   hi_rdata    forwarded HI
//   lo_rdata    forwarded LO
//   sel_rdata   HI or LO picked by rflag_e, else 0
//   pend_hi     a valid M or W entry writes HI
//   pend_lo     a valid M or W entry writes LO

module hilo_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_e,
  input  logic        flush_m,
  input  logic [2:0]  wflag_e,
  input  logic [31:0] hi_wdata_e,
  input  logic [31:0] lo_wdata_e,
  input  logic [2:0]  rflag_e,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic [31:0] sel_rdata,
  output logic        pend_hi,
  output logic        pend_lo
);

  logic [31:0] arch_hi, arch_lo;

  logic        m_v, m_whi, m_wlo;
  logic [31:0] m_hi, m_lo;

  logic        w_v, w_whi, w_wlo;
  logic [31:0] w_hi, w_lo;

  // A request is only real when the valid bit is set and it targets at least
  // one half; move-from ops carry [2]=0 and must never occupy a slot.
  logic e_valid;
  assign e_valid = wflag_e[2] & (wflag_e[1] | wflag_e[0]) & ~flush_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      arch_hi <= 32'd0;
      arch_lo <= 32'd0;
      m_v     <= 1'b0;
      m_whi   <= 1'b0;
      m_wlo   <= 1'b0;
      m_hi    <= 32'd0;
      m_lo    <= 32'd0;
      w_v     <= 1'b0;
      w_whi   <= 1'b0;
      w_wlo   <= 1'b0;
      w_hi    <= 32'd0;
      w_lo    <= 32'd0;
    end else if (stall) begin
      // An exception can still kill the M entry while the pipe is frozen.
      if (flush_m) begin
        m_v <= 1'b0;
      end
    end else begin
      m_v   <= e_valid;
      m_whi <= wflag_e[1];
      m_wlo <= wflag_e[0];
      m_hi  <= hi_wdata_e;
      m_lo  <= lo_wdata_e;

      w_v   <= m_v & ~flush_m;
      w_whi <= m_whi;
      w_wlo <= m_wlo;
      w_hi  <= m_hi;
      w_lo  <= m_lo;

      if (w_v && w_whi) begin
        arch_hi <= w_hi;
      end
      if (w_v && w_wlo) begin
        arch_lo <= w_lo;
      end
    end
  end

  // Per-half forwarding: the youngest valid writer of that half wins.
  always_comb begin
    hi_rdata = arch_hi;
    if (m_v && m_whi) begin
      hi_rdata = m_hi;
    end else if (w_v && w_whi) begin
      hi_rdata = w_hi;
    end

    lo_rdata = arch_lo;
    if (m_v && m_wlo) begin
      lo_rdata = m_lo;
    end else if (w_v && w_wlo) begin
      lo_rdata = w_lo;
    end
  end

  always_comb begin
    sel_rdata = 32'd0;
    if (rflag_e[2] && rflag_e[1]) begin
      sel_rdata = hi_rdata;
    end else if (rflag_e[2] && rflag_e[0]) begin
      sel_rdata = lo_rdata;
    end
  end

  assign pend_hi = (m_v & m_whi) | (w_v & w_whi);
  assign pend_lo = (m_v & m_wlo) | (w_v & w_wlo);

endmodule
